// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one load/store at a time, performs the
// access after a fixed latency, and holds the response until the core takes it.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_wr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] lat_addr;
    logic        lat_wr;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          access;
    logic [31:0]   a_addr;
    logic          a_wr;
    logic [1:0]    a_size;
    logic          a_signed;
    logic [31:0]   a_wdata;
    logic [AW-1:0] idx;
    logic          err;
    logic [4:0]    shift;
    logic [3:0]    be;
    logic [31:0]   wshift;
    logic [31:0]   rword;
    logic [31:0]   ext;
    logic [31:0]   load_val;

    // With LATENCY of 1 the access happens on the accept edge, so the live request
    // fields are used in IDLE and the latched copy everywhere else.
    always_comb begin
        accept   = req_valid_i && req_ready_o;
        a_addr   = (state == IDLE) ? req_addr_i   : lat_addr;
        a_wr     = (state == IDLE) ? req_wr_i     : lat_wr;
        a_size   = (state == IDLE) ? req_size_i   : lat_size;
        a_signed = (state == IDLE) ? req_signed_i : lat_signed;
        a_wdata  = (state == IDLE) ? req_wdata_i  : lat_wdata;
        idx      = a_addr[AW+1:2];
        err      = (a_size == 2'd3)
                || (a_size == 2'd1 && a_addr[0])
                || (a_size == 2'd2 && a_addr[1:0] != 2'b00)
                || (a_addr[31:2] >= 30'(DEPTH));
        shift    = {a_addr[1:0], 3'b000};
        case (a_size)
            2'd0:    be = 4'b0001 << a_addr[1:0];
            2'd1:    be = 4'b0011 << a_addr[1:0];
            default: be = 4'b1111;
        endcase
        wshift   = a_wdata << shift;
        rword    = mem[idx] >> shift;
        case (a_size)
            2'd0:    ext = {{24{a_signed & rword[7]}}, rword[7:0]};
            2'd1:    ext = {{16{a_signed & rword[15]}}, rword[15:0]};
            default: ext = rword;
        endcase
        load_val = (err || a_wr) ? 32'd0 : ext;
        access   = reset_i && (((state == IDLE) && accept && (LATENCY == 1))
                            || ((state == WAIT) && (cnt == 4'd1)));
    end

    always_ff @(posedge clk_i) begin
        if (access && a_wr && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req_ready_o  <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_error_o <= 1'b0;
            resp_rdata_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_addr    <= req_addr_i;
                        lat_wr      <= req_wr_i;
                        lat_size    <= req_size_i;
                        lat_signed  <= req_signed_i;
                        lat_wdata   <= req_wdata_i;
                        req_ready_o <= 1'b0;
                        cnt         <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_error_o <= err;
                            resp_rdata_o <= load_val;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state        <= RESP;
                        cnt          <= 4'd0;
                        resp_valid_o <= 1'b1;
                        resp_error_o <= err;
                        resp_rdata_o <= load_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                        resp_error_o <= 1'b0;
                        resp_rdata_o <= 32'd0;
                        req_ready_o  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 3, 1) checked against a
// byte-array memory model that applies the load/store/error rules directly.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_addr   [3];
    logic        req_wr     [3];
    logic [1:0]  req_size   [3];
    logic        req_signed [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_error [3];

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [3][4*DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
        .clk_i(clk), .reset_i(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_addr_i(req_addr[0]), .req_wr_i(req_wr[0]), .req_size_i(req_size[0]),
        .req_signed_i(req_signed[0]), .req_wdata_i(req_wdata[0]),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_rdata_o(resp_rdata[0]), .resp_error_o(resp_error[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
        .clk_i(clk), .reset_i(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_addr_i(req_addr[1]), .req_wr_i(req_wr[1]), .req_size_i(req_size[1]),
        .req_signed_i(req_signed[1]), .req_wdata_i(req_wdata[1]),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_rdata_o(resp_rdata[1]), .resp_error_o(resp_error[1])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clk_i(clk), .reset_i(rst_n[2]),
        .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
        .req_addr_i(req_addr[2]), .req_wr_i(req_wr[2]), .req_size_i(req_size[2]),
        .req_signed_i(req_signed[2]), .req_wdata_i(req_wdata[2]),
        .resp_valid_o(resp_valid[2]), .resp_ready_i(resp_ready[2]),
        .resp_rdata_o(resp_rdata[2]), .resp_error_o(resp_error[2])
    );

    function automatic int lat_of(input int u);
        case (u)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    // Reference behaviour: an access of 2**size bytes starting at addr, little-endian.
    function automatic void model_op(input int u, input logic [31:0] addr, input logic wr,
                                     input logic [1:0] size, input logic sgn,
                                     input logic [31:0] wdata,
                                     output logic err, output logic [31:0] rd);
        int n;
        logic [31:0] v;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'b00) || ((addr / 4) >= DEPTH);
        rd = 32'd0;
        if (err) return;
        n = 1 << size;
        if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[u][int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[u][int'(addr) + i]) << (8*i));
            if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
        end
    endfunction

    task automatic drive_req(input int u, input logic [31:0] addr, input logic wr,
                             input logic [1:0] size, input logic sgn, input logic [31:0] wdata);
        req_addr[u]   = addr;
        req_wr[u]     = wr;
        req_size[u]   = size;
        req_signed[u] = sgn;
        req_wdata[u]  = wdata;
        req_valid[u]  = 1'b1;
    endtask

    task automatic transact(input int u, input logic [31:0] addr, input logic wr,
                            input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                            input string name);
        logic        exp_err;
        logic [31:0] exp_rd;
        int guard;
        int lat;
        model_op(u, addr, wr, size, sgn, wdata, exp_err, exp_rd);
        @(negedge clk);
        drive_req(u, addr, wr, size, sgn, wdata);
        guard = 0;
        while (req_ready[u] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 50) begin
            bad++;
            $display("[TB] FAIL %s accept: req_ready=%b want 1", name, req_ready[u]);
            req_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[u] = 1'b0;
        lat = 1;
        while (resp_valid[u] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== lat_of(u)) begin
            bad++;
            $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, lat_of(u));
        end
        total++;
        if (resp_error[u] !== exp_err) begin
            bad++;
            $display("[TB] FAIL %s error @%h: got %b want %b", name, addr, resp_error[u], exp_err);
        end
        total++;
        if (resp_rdata[u] !== exp_rd) begin
            bad++;
            $display("[TB] FAIL %s rdata @%h: got %h want %h", name, addr, resp_rdata[u], exp_rd);
        end
        resp_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[u] = 1'b0;
        total++;
        if (req_ready[u] !== 1'b1 || resp_valid[u] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s turnaround: ready=%b valid=%b want 1/0", name,
                     req_ready[u], resp_valid[u]);
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) rst_n[u] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            total++;
            if ({req_ready[u], resp_valid[u], resp_error[u], resp_rdata[u]} !== 35'd0) begin
                bad++;
                $display("[TB] FAIL reset_outputs u%0d: ready=%b valid=%b err=%b rdata=%h want all 0",
                         u, req_ready[u], resp_valid[u], resp_error[u], resp_rdata[u]);
            end
        end
        for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            total++;
            if (req_ready[u] !== 1'b1) begin
                bad++;
                $display("[TB] FAIL reset_release u%0d: req_ready=%b want 1", u, req_ready[u]);
            end
        end
    endtask

    task automatic test_word();
        transact(0, 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, "word_store");
        transact(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, "word_load");
    endtask

    task automatic test_byte_sign();
        transact(0, 32'h13, 1'b1, 2'd0, 1'b0, 32'h0000_0080, "byte_store");
        transact(0, 32'h13, 1'b0, 2'd0, 1'b1, 32'h0, "byte_load_s");
        transact(0, 32'h13, 1'b0, 2'd0, 1'b0, 32'h0, "byte_load_u");
        transact(0, 32'h10, 1'b0, 2'd2, 1'b1, 32'h0, "word_after_byte");
    endtask

    task automatic test_errors();
        transact(0, 32'h11, 1'b0, 2'd1, 1'b0, 32'h0, "half_misaligned");
        transact(0, 32'h12, 1'b1, 2'd2, 1'b0, 32'h1111_2222, "word_misaligned");
        transact(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, "word_after_err");
        transact(0, 32'h10, 1'b0, 2'd3, 1'b0, 32'h0, "size3_load");
    endtask

    task automatic test_random(input int u, input int n);
        logic [31:0] addr;
        for (int w = 0; w < 16; w++) transact(u, 32'(w * 4), 1'b1, 2'd2, 1'b0, $urandom, "init");
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 9))
                0:       addr = 32'(4 * DEPTH + $urandom_range(0, 255));
                1:       addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: addr = 32'($urandom_range(0, 63));
            endcase
            transact(u, addr, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $urandom, "random");
        end
    endtask

    task automatic test_stall();
        logic        exp_err;
        logic [31:0] exp_rd;
        int guard;
        model_op(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, exp_err, exp_rd);
        @(negedge clk);
        drive_req(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        guard = 0;
        while (resp_valid[0] !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        drive_req(0, 32'h0, 1'b1, 2'd2, 1'b0, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== exp_rd || resp_error[0] !== exp_err) begin
                bad++;
                $display("[TB] FAIL stall_hold c%0d: valid=%b rdata=%h err=%b want 1/%h/%b",
                         i, resp_valid[0], resp_rdata[0], resp_error[0], exp_rd, exp_err);
            end
            total++;
            if (req_ready[0] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_ready c%0d: req_ready=%b want 0", i, req_ready[0]);
            end
            @(negedge clk);
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (resp_valid[0] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_stray c%0d: resp_valid=%b want 0", i, resp_valid[0]);
            end
            @(negedge clk);
        end
        transact(0, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, "stall_offer_dropped");
    endtask

    task automatic test_reset_abort();
        int guard;
        transact(1, 32'h20, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, "abort_pre");
        @(negedge clk);
        drive_req(1, 32'h20, 1'b1, 2'd2, 1'b0, 32'h1234_5678);
        guard = 0;
        while (req_ready[1] !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst_n[1]     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (req_ready[1] !== 1'b0 || resp_valid[1] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort_in_reset c%0d: ready=%b valid=%b want 0/0",
                         i, req_ready[1], resp_valid[1]);
            end
        end
        rst_n[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (resp_valid[1] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort_no_resp c%0d: resp_valid=%b want 0", i, resp_valid[1]);
            end
        end
        transact(1, 32'h20, 1'b0, 2'd2, 1'b0, 32'h0, "abort_old_data");
    endtask

    task automatic test_back_to_back();
        logic [31:0] t_addr  [8];
        logic        t_wr    [8];
        logic [1:0]  t_size  [8];
        logic        t_sgn   [8];
        logic [31:0] t_wdata [8];
        logic [31:0] q_rd [$];
        logic        q_err [$];
        logic        e;
        logic [31:0] r;
        int issued = 0;
        int got    = 0;
        int prev   = -1;
        int cyc    = 0;
        for (int w = 0; w < 4; w++) transact(2, 32'(w * 4), 1'b1, 2'd2, 1'b0, $urandom, "b2b_init");
        t_addr  = '{32'h0, 32'h1000, 32'h1000, 32'h6, 32'h6, 32'h4, 32'h7, 32'h0};
        t_wr    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        t_size  = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2};
        t_sgn   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        t_wdata = '{32'h0, 32'hA5A5_A5A5, 32'h0, 32'h0000_BEEF, 32'h0, 32'h0, 32'h0, 32'h0};
        resp_ready[2] = 1'b1;
        while (got < 8 && cyc < 100) begin
            if (resp_valid[2] === 1'b1) begin
                total++;
                if (q_rd.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL b2b_unexpected c%0d: response with nothing pending", cyc);
                end else begin
                    e = q_err.pop_front();
                    r = q_rd.pop_front();
                    if (resp_error[2] !== e || resp_rdata[2] !== r) begin
                        bad++;
                        $display("[TB] FAIL b2b_resp%0d: err=%b rdata=%h want %b/%h",
                                 got, resp_error[2], resp_rdata[2], e, r);
                    end
                end
                if (prev >= 0) begin
                    total++;
                    if (cyc - prev !== 2) begin
                        bad++;
                        $display("[TB] FAIL b2b_gap%0d: got %0d cycles want 2", got, cyc - prev);
                    end
                end
                prev = cyc;
                got++;
            end
            if (issued < 8) begin
                if (req_ready[2] === 1'b1) begin
                    model_op(2, t_addr[issued], t_wr[issued], t_size[issued], t_sgn[issued],
                             t_wdata[issued], e, r);
                    q_err.push_back(e);
                    q_rd.push_back(r);
                    drive_req(2, t_addr[issued], t_wr[issued], t_size[issued], t_sgn[issued],
                              t_wdata[issued]);
                    issued++;
                end
            end else begin
                req_valid[2] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid[2]  = 1'b0;
        resp_ready[2] = 1'b0;
        total++;
        if (got !== 8) begin
            bad++;
            $display("[TB] FAIL b2b_count: got %0d responses want 8", got);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst_n[u]      = 1'b0;
            req_valid[u]  = 1'b0;
            req_addr[u]   = 32'd0;
            req_wr[u]     = 1'b0;
            req_size[u]   = 2'd0;
            req_signed[u] = 1'b0;
            req_wdata[u]  = 32'd0;
            resp_ready[u] = 1'b0;
        end
        $display("[TB] starting dmem_responder bench");
        test_reset();
        test_word();
        test_byte_sign();
        test_errors();
        test_random(0, 40);
        test_stall();
        test_reset_abort();
        test_random(1, 30);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
